// File: rtl/fan_pwm_ctrl_if.sv
// Bus bundle between the board-management register logic and the multi-channel fan PWM controller.
interface fan_pwm_ctrl_if #(
    parameter int CHANNELS = 2,
    parameter int RES_BITS = 8
);
    logic                         enable;
    logic [CHANNELS*RES_BITS-1:0] duty_in;
    logic [CHANNELS-1:0]          duty_load;
    logic [CHANNELS-1:0]          tach_in;
    logic [CHANNELS-1:0]          fan_out;
    logic [CHANNELS*RES_BITS-1:0] duty_cur;
    logic                         period_strobe;
    logic [CHANNELS-1:0]          stall;

    modport master (
        output enable, duty_in, duty_load, tach_in,
        input  fan_out, duty_cur, period_strobe, stall
    );

    modport slave (
        input  enable, duty_in, duty_load, tach_in,
        output fan_out, duty_cur, period_strobe, stall
    );
endinterface

// File: rtl/fan_pwm_ctrl.sv
// Multi-channel fan PWM with kick-start and slew-limited ramp per channel.
// Tachometer stall detection is compiled in when FAN_PWM_TACH_EN is defined.
module fan_pwm_ctrl #(
    parameter int CHANNELS     = 2,
    parameter int RES_BITS     = 8,
    parameter int PRESCALE     = 64,
    parameter int RAMP_STEP    = 4,
    parameter int KICK_PERIODS = 16,
    parameter int TACH_WINDOW  = 256
) (
    input logic          clk,
    input logic          reset_n,
    fan_pwm_ctrl_if.slave bus
);
    typedef enum logic [1:0] {ST_OFF, ST_KICK, ST_RAMP, ST_STEADY} state_t;

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int KW = (KICK_PERIODS > 1) ? $clog2(KICK_PERIODS) : 1;
    localparam logic [PW-1:0]       PRE_LAST  = PW'(PRESCALE - 1);
    localparam logic [KW-1:0]       KICK_LOAD = KW'((KICK_PERIODS > 0) ? KICK_PERIODS - 1 : 0);
    localparam logic [RES_BITS-1:0] FULL      = '1;
    localparam logic [RES_BITS-1:0] STEP_RES  = RES_BITS'(RAMP_STEP);
    localparam logic [RES_BITS:0]   STEP_EXT  = (RES_BITS + 1)'(RAMP_STEP);

    logic [PW-1:0]       presc_cnt;
    logic [RES_BITS-1:0] pwm_cnt;
    logic                tick;
    logic                boundary;
    logic                strobe_r;
    logic [CHANNELS-1:0] fan_r;

    logic [RES_BITS-1:0] target   [CHANNELS];
    logic [RES_BITS-1:0] duty     [CHANNELS];
    logic [RES_BITS-1:0] duty_nxt [CHANNELS];
    state_t              state    [CHANNELS];
    state_t              state_nxt[CHANNELS];
    logic [KW-1:0]       kick_cnt [CHANNELS];
    logic [KW-1:0]       kick_nxt [CHANNELS];

    // One ramp step toward tgt; the extra bit catches overflow/borrow so the result clamps instead of wrapping.
    function automatic logic [RES_BITS-1:0] step_toward(input logic [RES_BITS-1:0] cur,
                                                        input logic [RES_BITS-1:0] tgt);
        logic [RES_BITS:0] up;
        logic [RES_BITS:0] dn;
        up = {1'b0, cur} + STEP_EXT;
        dn = {1'b0, cur} - STEP_EXT;
        if (cur < tgt)
            return (up > {1'b0, tgt}) ? tgt : up[RES_BITS-1:0];
        else if (dn[RES_BITS] || (dn < {1'b0, tgt}))
            return tgt;
        else
            return dn[RES_BITS-1:0];
    endfunction

    assign tick     = (presc_cnt == PRE_LAST);
    assign boundary = tick && (pwm_cnt == FULL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
            strobe_r  <= 1'b0;
            fan_r     <= '0;
        end else begin
            presc_cnt <= tick ? '0 : presc_cnt + PW'(1);
            if (tick)
                pwm_cnt <= pwm_cnt + RES_BITS'(1);
            strobe_r <= boundary;
            for (int k = 0; k < CHANNELS; k++)
                fan_r[k] <= bus.enable && ((pwm_cnt < duty[k]) || (duty[k] == FULL));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < CHANNELS; k++) begin
                target[k]   <= '0;
                duty[k]     <= '0;
                state[k]    <= ST_OFF;
                kick_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (bus.duty_load[k])
                    target[k] <= bus.duty_in[k*RES_BITS +: RES_BITS];
                duty[k]     <= duty_nxt[k];
                state[k]    <= state_nxt[k];
                kick_cnt[k] <= kick_nxt[k];
            end
        end
    end

    // Disable overrides everything immediately; otherwise channels only move at period boundaries.
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            state_nxt[k] = state[k];
            duty_nxt[k]  = duty[k];
            kick_nxt[k]  = kick_cnt[k];
            if (!bus.enable) begin
                state_nxt[k] = ST_OFF;
                duty_nxt[k]  = '0;
                kick_nxt[k]  = '0;
            end else if (boundary) begin
                case (state[k])
                    ST_OFF: begin
                        if (target[k] != '0) begin
                            if (KICK_PERIODS > 0) begin
                                state_nxt[k] = ST_KICK;
                                duty_nxt[k]  = FULL;
                                kick_nxt[k]  = KICK_LOAD;
                            end else begin
                                state_nxt[k] = ST_RAMP;
                            end
                        end
                    end
                    ST_KICK: begin
                        if (kick_cnt[k] == '0) begin
                            state_nxt[k] = ST_RAMP;
                            duty_nxt[k]  = (target[k] < STEP_RES) ? target[k] : STEP_RES;
                        end else begin
                            kick_nxt[k] = kick_cnt[k] - KW'(1);
                        end
                    end
                    ST_RAMP, ST_STEADY: begin
                        duty_nxt[k] = step_toward(duty[k], target[k]);
                        if (duty_nxt[k] == target[k])
                            state_nxt[k] = (target[k] == '0) ? ST_OFF : ST_STEADY;
                        else
                            state_nxt[k] = ST_RAMP;
                    end
                    default: begin
                        state_nxt[k] = ST_OFF;
                        duty_nxt[k]  = '0;
                    end
                endcase
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_duty_out
        assign bus.duty_cur[g*RES_BITS +: RES_BITS] = duty[g];
    end
    assign bus.fan_out       = fan_r;
    assign bus.period_strobe = strobe_r;

`ifdef FAN_PWM_TACH_EN
    localparam int WW = (TACH_WINDOW > 1) ? $clog2(TACH_WINDOW) : 1;

    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] sync2;
    logic [CHANNELS-1:0] tach_prev;
    logic [CHANNELS-1:0] tach_rise;
    logic [CHANNELS-1:0] edge_seen;
    logic [CHANNELS-1:0] stall_r;
    logic [WW-1:0]       win_cnt;
    logic                win_end;

    assign tach_rise = sync2 & ~tach_prev;
    assign win_end   = boundary && (win_cnt == WW'(TACH_WINDOW - 1));

    // A rise on the window's final clk still counts for that window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1     <= '0;
            sync2     <= '0;
            tach_prev <= '0;
            edge_seen <= '0;
            stall_r   <= '0;
            win_cnt   <= '0;
        end else begin
            sync1     <= bus.tach_in;
            sync2     <= sync1;
            tach_prev <= sync2;
            if (boundary)
                win_cnt <= win_end ? '0 : win_cnt + WW'(1);
            for (int k = 0; k < CHANNELS; k++) begin
                if (state_nxt[k] == ST_OFF)
                    stall_r[k] <= 1'b0;
                else if (win_end)
                    stall_r[k] <= (state[k] == ST_STEADY) && (duty[k] != '0) &&
                                  !(edge_seen[k] || tach_rise[k]);
                if (win_end)
                    edge_seen[k] <= 1'b0;
                else if (tach_rise[k])
                    edge_seen[k] <= 1'b1;
            end
        end
    end

    assign bus.stall = stall_r;
`else
    logic unused_tach;
    assign unused_tach = ^{bus.tach_in, TACH_WINDOW[0]};
    assign bus.stall   = '0;
`endif
endmodule

// File: tb/tb_fan_pwm_ctrl.sv
// Scoreboard bench for fan_pwm_ctrl: 2 channels, 4-bit duty, prescale 2, ramp step 4, kick 2 periods.
module tb_fan_pwm_ctrl;
    localparam int CH = 2;
    localparam int RB = 4;
    localparam int PS = 2;
    localparam int RS = 4;
    localparam int KP = 2;
    localparam int TW = 4;

    typedef struct {
        logic [3:0] d0;
        logic [3:0] d1;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   period_idx = 0;

    always #5 clk = ~clk;

    fan_pwm_ctrl_if #(.CHANNELS(CH), .RES_BITS(RB)) bus ();

    fan_pwm_ctrl #(
        .CHANNELS(CH), .RES_BITS(RB), .PRESCALE(PS),
        .RAMP_STEP(RS), .KICK_PERIODS(KP), .TACH_WINDOW(TW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int high_count(input logic [3:0] d);
        return (d == 4'hF) ? 31 : 2 * int'(d);
    endfunction

    task automatic push_exp(input logic [3:0] d0, input logic [3:0] d1);
        exp_t e;
        e.d0 = d0;
        e.d1 = d1;
        exp_q.push_back(e);
    endtask

    task automatic wait_strobe();
        int n = 0;
        while (bus.period_strobe !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.period_strobe !== 1'b1)
            $display("[TB] FAIL strobe_wait: period_strobe=%b after %0d clk, want 1 within 40", bus.period_strobe, n);
        else
            passes++;
    endtask

    task automatic load_duty(input int ch, input logic [3:0] val);
        @(negedge clk);
        bus.duty_in[ch*RB +: RB] = val;
        bus.duty_load[ch]        = 1'b1;
        @(negedge clk);
        bus.duty_load = '0;
    endtask

    // Pops one expected (duty0, duty1) per period and checks duty_cur and fan_out high time.
    task automatic observe(input int n);
        for (int p = 0; p < n; p++) begin
            exp_t e;
            int   c0;
            int   c1;
            wait_strobe();
            period_idx++;
            checks++;
            if (exp_q.size() == 0) begin
                $display("[TB] FAIL scoreboard_empty: period %0d has no expected entry", period_idx);
                return;
            end
            passes++;
            e = exp_q.pop_front();
            checks++;
            if (bus.duty_cur[3:0] !== e.d0)
                $display("[TB] FAIL duty_ch0 period %0d: got %h want %h", period_idx, bus.duty_cur[3:0], e.d0);
            else
                passes++;
            checks++;
            if (bus.duty_cur[7:4] !== e.d1)
                $display("[TB] FAIL duty_ch1 period %0d: got %h want %h", period_idx, bus.duty_cur[7:4], e.d1);
            else
                passes++;
            c0 = 0;
            c1 = 0;
            repeat (31) begin
                @(negedge clk);
                c0 += int'(bus.fan_out[0]);
                c1 += int'(bus.fan_out[1]);
            end
            checks++;
            if (c0 !== high_count(e.d0))
                $display("[TB] FAIL fan0_high period %0d: got %0d clk want %0d", period_idx, c0, high_count(e.d0));
            else
                passes++;
            checks++;
            if (c1 !== high_count(e.d1))
                $display("[TB] FAIL fan1_high period %0d: got %0d clk want %0d", period_idx, c1, high_count(e.d1));
            else
                passes++;
        end
    endtask

    task automatic test_reset();
        int n;
        reset_n       = 1'b0;
        bus.enable    = 1'b1;
        bus.duty_in   = '0;
        bus.duty_load = '0;
        bus.tach_in   = '0;
        repeat (3) @(negedge clk);
        checks += 4;
        if (bus.fan_out !== 2'b00) $display("[TB] FAIL reset_fan_out: got %b want 00", bus.fan_out);
        else passes++;
        if (bus.duty_cur !== 8'h00) $display("[TB] FAIL reset_duty_cur: got %h want 00", bus.duty_cur);
        else passes++;
        if (bus.period_strobe !== 1'b0) $display("[TB] FAIL reset_strobe: got %b want 0", bus.period_strobe);
        else passes++;
        if (bus.stall !== 2'b00) $display("[TB] FAIL reset_stall: got %b want 00", bus.stall);
        else passes++;
        reset_n = 1'b1;
        for (int r = 0; r < 2; r++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (bus.period_strobe !== 1'b1 && n < 40);
            checks++;
            if (n !== 32) $display("[TB] FAIL strobe_interval %0d: got %0d clk want 32", r, n);
            else passes++;
        end
    endtask

    task automatic test_kick_ramp();
        load_duty(0, 4'h8);
        push_exp(4'hF, 4'h0);
        push_exp(4'hF, 4'h0);
        push_exp(4'h4, 4'h0);
        push_exp(4'h8, 4'h0);
        push_exp(4'h8, 4'h0);
        observe(5);
    endtask

    task automatic test_off_path();
        load_duty(1, 4'hF);
        push_exp(4'h8, 4'hF);
        push_exp(4'h8, 4'hF);
        push_exp(4'h8, 4'h4);
        push_exp(4'h8, 4'h8);
        push_exp(4'h8, 4'hC);
        push_exp(4'h8, 4'hF);
        observe(6);
        load_duty(1, 4'h0);
        push_exp(4'h8, 4'hB);
        push_exp(4'h8, 4'h7);
        push_exp(4'h8, 4'h3);
        push_exp(4'h8, 4'h0);
        push_exp(4'h8, 4'h0);
        observe(5);
    endtask

    // The second load lands on the boundary clk, so that boundary must still chase the old target.
    task automatic test_coincident_load();
        load_duty(0, 4'hF);
        push_exp(4'hC, 4'h0);
        observe(1);
        bus.duty_in[3:0] = 4'h2;
        bus.duty_load[0] = 1'b1;
        @(negedge clk);
        bus.duty_load = '0;
        push_exp(4'hF, 4'h0);
        push_exp(4'hB, 4'h0);
        push_exp(4'h7, 4'h0);
        push_exp(4'h3, 4'h0);
        push_exp(4'h2, 4'h0);
        observe(5);
    endtask

    task automatic test_enable();
        repeat (3) @(negedge clk);
        checks++;
        if (bus.fan_out[0] !== 1'b1) $display("[TB] FAIL en_pre_fan0: got %b want 1", bus.fan_out[0]);
        else passes++;
        bus.enable = 1'b0;
        @(negedge clk);
        checks += 2;
        if (bus.fan_out !== 2'b00) $display("[TB] FAIL en_drop_fan: got %b want 00", bus.fan_out);
        else passes++;
        if (bus.duty_cur !== 8'h00) $display("[TB] FAIL en_drop_duty: got %h want 00", bus.duty_cur);
        else passes++;
        wait_strobe();
        checks++;
        if (bus.duty_cur !== 8'h00) $display("[TB] FAIL en_low_boundary_duty: got %h want 00", bus.duty_cur);
        else passes++;
        repeat (5) @(negedge clk);
        bus.enable = 1'b1;
        push_exp(4'hF, 4'h0);
        push_exp(4'hF, 4'h0);
        push_exp(4'h2, 4'h0);
        push_exp(4'h2, 4'h0);
        observe(4);
    endtask

    task automatic test_tach();
        int n;
`ifdef FAN_PWM_TACH_EN
        repeat (9 * 32) @(negedge clk);
        checks++;
        if (bus.stall !== 2'b01) $display("[TB] FAIL stall_set: got %b want 01", bus.stall);
        else passes++;
        bus.tach_in[0] = 1'b1;
        repeat (4) @(negedge clk);
        bus.tach_in[0] = 1'b0;
        n = 0;
        while (bus.stall[0] !== 1'b0 && n < 6 * 32) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.stall[0] !== 1'b0) $display("[TB] FAIL stall_clear: got %b want 0 after tach pulse", bus.stall[0]);
        else passes++;
`else
        bus.tach_in[0] = 1'b1;
        repeat (4) @(negedge clk);
        bus.tach_in[0] = 1'b0;
        n = 0;
        while (n < 9 * 32) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.stall !== 2'b00) $display("[TB] FAIL stall_tied: got %b want 00", bus.stall);
        else passes++;
`endif
    endtask

    task automatic test_async_reset();
        int n;
        wait_strobe();
        @(negedge clk);
        checks++;
        if (bus.fan_out[0] !== 1'b1) $display("[TB] FAIL arst_pre_fan0: got %b want 1", bus.fan_out[0]);
        else passes++;
        #2 reset_n = 1'b0;
        #1;
        checks += 2;
        if (bus.duty_cur !== 8'h00) $display("[TB] FAIL arst_duty: got %h want 00", bus.duty_cur);
        else passes++;
        if (bus.fan_out !== 2'b00) $display("[TB] FAIL arst_fan: got %b want 00", bus.fan_out);
        else passes++;
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.period_strobe !== 1'b1 && n < 40);
        checks += 2;
        if (n !== 32) $display("[TB] FAIL arst_first_period: got %0d clk want 32", n);
        else passes++;
        if (bus.duty_cur !== 8'h00) $display("[TB] FAIL arst_target_cleared: got %h want 00", bus.duty_cur);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_kick_ramp();
        test_off_path();
        test_coincident_load();
        test_enable();
        test_tach();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
